// File: rtl/mul_seq_pkg.sv
// Shared definitions for the RV32M multiplier sequencer: funct encodings,
// FSM states, default width and operand-signedness decode.
package mul_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } funct_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_FIX_LO = 3'd2,
    ST_FIX_HI = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // rs1 is signed for MULH and MULHSU.
  function automatic logic is_signed_rs1(input logic [1:0] f);
    logic r;
    case (f)
      2'b01:   r = 1'b1;
      2'b10:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // rs2 is signed for MULH only.
  function automatic logic is_signed_rs2(input logic [1:0] f);
    logic r;
    case (f)
      2'b01:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle between the execute stage and the multiplier.
interface mul_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      funct;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  // Pipeline side: issues operations and consumes results.
  modport master (
    output in_valid, funct, rs1, rs2, kill, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, funct, rs1, rs2, kill, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mul_seq_adder.sv
// Ripple-carry adder built from a chain of full_adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end
endmodule

// File: rtl/mul_seq.sv
// Multi-cycle RV32M multiplier: shift-and-add over XLEN iterations on operand
// magnitudes, then a two-step two's-complement fixup of the 2*XLEN product.
// Every addition goes through the single shared ripple adder.
module mul_seq
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic        clk,
  input logic        rst_n,
  mul_seq_if.slave   bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic            neg_q, neg_d;
  funct_e          funct_q, funct_d;
  logic            carry_q, carry_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;

  // Shared adder operands.
  logic [XLEN-1:0] add_a, add_b, add_sum;
  logic            add_cin, add_cout;

  // Intermediate values inside the next-state logic.
  logic            calc_c;
  logic [XLEN-1:0] calc_h;
  logic [XLEN-1:0] fix_hi;

  // Operand sign / magnitude decode at accept time (dedicated negators).
  logic            sgn1, sgn2;
  logic [XLEN-1:0] mag1, mag2;

  assign sgn1 = is_signed_rs1(bus.funct) & bus.rs1[XLEN-1];
  assign sgn2 = is_signed_rs2(bus.funct) & bus.rs2[XLEN-1];
  assign mag1 = sgn1 ? (~bus.rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : bus.rs1;
  assign mag2 = sgn2 ? (~bus.rs2 + {{(XLEN-1){1'b0}}, 1'b1}) : bus.rs2;

  ripple_adder #(.W(XLEN)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state, datapath and adder operand selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mcand_d     = mcand_q;
    neg_d       = neg_q;
    funct_d     = funct_q;
    carry_d     = carry_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    add_a       = {XLEN{1'b0}};
    add_b       = {XLEN{1'b0}};
    add_cin     = 1'b0;
    calc_c      = 1'b0;
    calc_h      = hi_q;
    fix_hi      = hi_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && !bus.kill) begin
          mcand_d = mag1;
          lo_d    = mag2;
          hi_d    = {XLEN{1'b0}};
          cnt_d   = {CW{1'b0}};
          neg_d   = sgn1 ^ sgn2;
          funct_d = funct_e'(bus.funct);
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        add_a = hi_q;
        add_b = mcand_q;
        if (lo_q[0]) begin
          calc_c = add_cout;
          calc_h = add_sum;
        end else begin
          calc_c = 1'b0;
          calc_h = hi_q;
        end
        hi_d = {calc_c, calc_h[XLEN-1:1]};
        lo_d = {calc_h[0], lo_q[XLEN-1:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = ST_FIX_LO;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ST_FIX_LO: begin
        add_a   = ~lo_q;
        add_cin = 1'b1;
        if (neg_q) begin
          lo_d    = add_sum;
          carry_d = add_cout;
        end else begin
          carry_d = 1'b0;
        end
        state_d = ST_FIX_HI;
      end

      ST_FIX_HI: begin
        add_a   = ~hi_q;
        add_cin = carry_q;
        if (neg_q) begin
          fix_hi = add_sum;
        end else begin
          fix_hi = hi_q;
        end
        hi_d     = fix_hi;
        result_d = (funct_q == MUL_LO) ? lo_q : fix_hi;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        // First DONE cycle registers out_valid; release happens only once
        // the consumer has seen it.
        if (out_valid_q && bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush abandons any in-flight operation; the last result is kept.
    if (bus.kill && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
      cnt_d       = {CW{1'b0}};
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      hi_q        <= {XLEN{1'b0}};
      lo_q        <= {XLEN{1'b0}};
      mcand_q     <= {XLEN{1'b0}};
      neg_q       <= 1'b0;
      funct_q     <= MUL_LO;
      carry_q     <= 1'b0;
      result_q    <= {XLEN{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mcand_q     <= mcand_d;
      neg_q       <= neg_d;
      funct_q     <= funct_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle RV32M multiplier sequencer. Computes MUL, MULH, MULHSU and MULHU by shift-and-add over XLEN iterations. All iteration and sign-fixup additions go through one shared ripple-carry adder built from `full_adder` cells. Sits in the execute stage beside the ALU: it accepts an operation over a valid/ready handshake and stalls the pipeline until the result is consumed.

## Interface
- `XLEN`, default 32: operand and result width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept; high only in IDLE.
- `funct` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RV32M `funct3[1:0]`).
- `rs1` in XLEN: multiplicand; signed for MULH and MULHSU.
- `rs2` in XLEN: multiplier; signed for MULH only.
- `kill` in 1: synchronous abort (pipeline flush).
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts result.
- `result` out XLEN: MUL gives product[XLEN-1:0]; all others give product[2XLEN-1:XLEN].
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, CALC, FIX_LO, FIX_HI, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch the operand magnitudes and `funct`, then go to CALC.
  - Latch `neg` = (signed rs1 and rs1[XLEN-1]) XOR (signed rs2 and rs2[XLEN-1]).
  - Magnitude = two's-complement negation of a negative signed operand (dedicated logic), else the raw value.
  - MUL treats both operands as unsigned; its low word is identical either way.
- CALC, XLEN cycles, counter 0..XLEN-1:
  - If `lo[0]`, then `{c,hi}` = hi + mcand (XLEN+1 bits, via the shared adder); else `{c,hi}` = {0,hi}.
  - Then `{hi,lo}` = `{c,hi,lo} >> 1`.
  - The multiplier is held in `lo`.
  - Go to FIX_LO when the counter reaches XLEN-1.
- FIX_LO: if `neg`, lo = ~lo + 1 via the adder and save the carry-out; else pass through with saved carry 0.
- FIX_HI: if `neg`, hi = ~hi + saved carry via the adder; else pass through. Then go to DONE.
- DONE:
  - `out_valid`=1 and `result` is stable.
  - On `out_ready`, go to IDLE.
- `kill` in any non-IDLE state forces IDLE on the next edge. It suppresses `out_valid` and does not alter `result`.
- `kill` in IDLE with `in_valid`: the request is not accepted.
- Fixup cycles always run, so latency is constant regardless of sign.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, counter 0, product register 0.
- Accept at edge E0.
  - CALC occupies cycles E1..E(XLEN).
  - FIX_LO occupies E(XLEN+1), FIX_HI occupies E(XLEN+2).
  - `out_valid` is high from E(XLEN+3).
  - Latency = XLEN+3 clocks, i.e. 35 for XLEN=32.
- `out_ready` held high in DONE: `out_valid` drops and `in_ready` rises one edge later. There is no back-to-back accept in the same cycle as result release.
- `out_ready` low: DONE holds indefinitely and `result` is stable.
- `kill` and `out_ready` in the same DONE cycle: both go to IDLE, and the result counts as consumed.
- Async reset mid-CALC: all state clears immediately. The next accepted operation is unaffected.
- Operand -2^(XLEN-1): its magnitude 2^(XLEN-1) fits in XLEN unsigned bits. No overflow case exists.

## Structure
- `mul_pkg`:
  - `funct` encodings (`MUL_LO`, `MUL_HSS`, `MUL_HSU`, `MUL_HUU`).
  - State enum.
  - `XLEN` default.
  - `is_signed_rs1`/`is_signed_rs2` decode functions.
- Sub-module `ripple_adder`:
  - Parameter `W`; ports `a`, `b`, `cin`, `sum`, `cout`.
  - A generate chain of `full_adder` instances.
  - Instantiated once with `W`=XLEN and shared by CALC and both FIX states via an operand mux.

## Test plan
- MUL 7 × 6 → `result`=0x0000002A, `out_valid` exactly 35 clocks after accept.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → `result`=0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULH 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; same operands with MUL → 0x00000001.
- `out_ready` held low 10 cycles in DONE → `result` stable and `in_ready`=0 throughout; release → `in_ready`=1 the next cycle.
- `kill` at CALC cycle 5, and separately `rst_n` low at CALC cycle 12 → IDLE, `out_valid` never asserted. A following MUL 3 × 5 returns 0x0000000F with normal latency.
